// File: rtl/codif_pkg.sv
// Shared types and helpers for the 8-line priority encoder.
package codif_pkg;

  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    RELEASE
  } state_e;

  function automatic logic [CODE_W-1:0] prio_enc(
    input logic [N_LINES-1:0] v
  );
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_LINES; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  function automatic logic is_multi(
    input logic [N_LINES-1:0] v
  );
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Input synchronizer plus debouncer for a bank of switch-like lines.
// s is the confirmed vector; stable says it has held DEB_CYCLES+1 samples.
module sync_debounce
  import codif_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] din,
  output logic [N_LINES-1:0] s,
  output logic               stable
);

  localparam logic [7:0] DEB_MAX = 8'(DEB_CYCLES);

  logic [SYNC_STAGES-1:0][N_LINES-1:0] sync_q, sync_d;
  logic [N_LINES-1:0] prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [N_LINES-1:0] sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_out;
    cnt_d  = cnt_q;
    if (sync_out != prev_q) begin
      cnt_d = 8'd0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
      cnt_q  <= 8'd0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign s      = prev_q;
  assign stable = (cnt_q == DEB_MAX);

endmodule

// File: rtl/codif_prio8.sv
// Sequential 8-to-3 priority encoder with valid/ack handshake.
module codif_prio8
  import codif_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_LINES-1:0] d,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  input  logic              ack,
  output logic              multi,
  output logic              busy
);

  logic [N_LINES-1:0] s;
  logic               stable;

  state_e            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              multi_q, multi_d;
  logic              busy_q, busy_d;

  sync_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (d),
    .s     (s),
    .stable(stable)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = valid_q;
    multi_d = multi_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (stable && s != '0) begin
          code_d  = prio_enc(s);
          multi_d = is_multi(s);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // a fresh non-zero vector here is ignored until all lines drop
        if (stable && s == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
      busy_q  <= busy_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign multi = multi_q;
  assign busy  = busy_q;

endmodule
